pool_window_gen: RTL and testbench

POOL_WINDOW_GEN -- requirements
Module: pool_window_gen

---
 rtl/pool_window_gen.sv | 122 ++++++++++++
 tb/tb_pool_window_gen.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_window_gen.sv
// 2x2 stride-2 pooling window generator over a raster pixel stream; POOL_WIN_LAST_EN adds win_last.
// Latency: a window is visible the cycle after its bottom-right pixel is accepted.
// Backpressure: in_ready = !out_valid || out_ready; a held window stalls the input, no internal buffering.
module pool_window_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_W      = 24,
    parameter int IMG_H      = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] n1,
    output logic [DATA_WIDTH-1:0] n2,
    output logic [DATA_WIDTH-1:0] n3,
    output logic [DATA_WIDTH-1:0] n4
`ifdef POOL_WIN_LAST_EN
    ,
    output logic                  win_last
`endif
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] bl_q;
    logic [DATA_WIDTH-1:0] n1_q, n2_q, n3_q, n4_q;
    logic                  vld_q, vld_d;
    logic                  accept;
    logic                  load_win;
    logic [DATA_WIDTH-1:0] lbuf [IMG_W];

    assign in_ready = !vld_q || out_ready;
    assign accept   = in_valid && in_ready;
    // Row/column parity decides the pixel's role; both dimensions are even so parity is just bit 0.
    assign load_win = accept && row_q[0] && col_q[0];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (load_win) begin
            vld_d = 1'b1;
        end else if (out_ready) begin
            vld_d = 1'b0;
        end
    end

    // Line buffer holds the even row; not reset since every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (accept && !row_q[0]) begin
            lbuf[col_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            vld_q <= 1'b0;
            bl_q  <= '0;
            n1_q  <= '0;
            n2_q  <= '0;
            n3_q  <= '0;
            n4_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            vld_q <= vld_d;
            if (accept && row_q[0] && !col_q[0]) begin
                bl_q <= in_data;
            end
            if (load_win) begin
                n1_q <= lbuf[col_q - CW'(1)];
                n2_q <= lbuf[col_q];
                n3_q <= bl_q;
                n4_q <= in_data;
            end
        end
    end

`ifdef POOL_WIN_LAST_EN
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (load_win) begin
            last_q <= (row_q == ROW_MAX) && (col_q == COL_MAX);
        end else if (out_ready) begin
            last_q <= 1'b0;
        end
    end

    assign win_last = last_q;
`endif

    assign out_valid = vld_q;
    assign n1        = n1_q;
    assign n2        = n2_q;
    assign n3        = n3_q;
    assign n4        = n4_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Scoreboard bench for pool_window_gen: frame-level reference model feeds an expected-window queue.
module tb_pool_window_gen;

    localparam int DW = 16;
    localparam int W  = 24;
    localparam int H  = 24;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [DW-1:0] d;
        bit            last;
    } win_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] n1, n2, n3, n4;
`ifdef POOL_WIN_LAST_EN
    logic          win_last;
`endif

    win_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_win = 0;
    int   stalls = 0;
    bit   rnd_mode = 1'b0;

    bit            hold_pend = 1'b0;
    logic [DW-1:0] h1, h2, h3, h4;

    pool_window_gen #(
        .DATA_WIDTH(DW),
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .n1(n1),
        .n2(n2),
        .n3(n3),
        .n4(n4)
`ifdef POOL_WIN_LAST_EN
        ,
        .win_last(win_last)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d windows still expected", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Downstream randomly stalls in random mode, otherwise always ready.
    always @(posedge clk) begin
        #1;
        out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: compares each consumed window with the head of the expected queue.
    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else if (out_valid) begin
            if (hold_pend) begin
                chk("hold_n1", n1, h1);
                chk("hold_n2", n2, h2);
                chk("hold_n3", n3, h3);
                chk("hold_n4", n4, h4);
            end
            if (out_ready) begin
                hold_pend = 1'b0;
                if (exp_q.size() == 0) begin
                    chk("unexpected_window", 1, 0);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    n_win++;
                    chk("win_n1", n1, e.a);
                    chk("win_n2", n2, e.b);
                    chk("win_n3", n3, e.c);
                    chk("win_n4", n4, e.d);
`ifdef POOL_WIN_LAST_EN
                    chk("win_last", win_last, e.last);
`endif
                end
            end else begin
                chk("stall_in_ready", in_ready, 0);
                hold_pend = 1'b1;
                h1 = n1;
                h2 = n2;
                h3 = n3;
                h4 = n4;
            end
        end else begin
            hold_pend = 1'b0;
            chk("idle_in_ready", in_ready, 1);
        end
    end

    // Builds one frame, queues its windows in grid order, then streams it in raster order.
    // abort_at >= 0 stops after that many accepted pixels.
    task automatic send_frame(input bit rnd, input int abort_at, input bit special);
        logic [DW-1:0] img [H][W];
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = DW'($urandom);
        if (special) begin
            img[0][0] = 16'h7E00;
            img[0][1] = 16'h8000;
            img[1][0] = 16'hFC00;
            img[1][1] = 16'h7C01;
            img[H-2][W-2] = 16'h0000;
            img[H-1][W-1] = 16'hFFFF;
        end
        for (int wr = 0; wr < H / 2; wr++) begin
            for (int wc = 0; wc < W / 2; wc++) begin
                win_t e;
                e.a = img[2*wr][2*wc];
                e.b = img[2*wr][2*wc+1];
                e.c = img[2*wr+1][2*wc];
                e.d = img[2*wr+1][2*wc+1];
                e.last = (wr == H / 2 - 1) && (wc == W / 2 - 1);
                exp_q.push_back(e);
            end
        end
        for (int p = 0; p < W * H; p++) begin
            bit acc = 1'b0;
            int tries = 0;
            if (p == abort_at) begin
                in_valid = 1'b0;
                return;
            end
            in_data = img[p / W][p % W];
            while (!acc && tries < 2000) begin
                in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                if (!acc) begin
                    tries++;
                    if (!rnd) stalls++;
                end
            end
            if (!acc) begin
                chk("pixel_accept_timeout", tries, 0);
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int w0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_n1", n1, 0);
        chk("rst_n4", n4, 0);
`ifdef POOL_WIN_LAST_EN
        chk("rst_win_last", win_last, 0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        // Special fp16 encodings must pass through untouched.
        send_frame(1'b0, -1, 1'b1);
        drain();

        // Two back-to-back frames with no stalls anywhere.
        w0 = n_win;
        stalls = 0;
        send_frame(1'b0, -1, 1'b0);
        send_frame(1'b0, -1, 1'b0);
        drain();
        chk("two_frame_windows", n_win - w0, 288);
        chk("no_bubbles", stalls, 0);

        // Reset mid-frame: pending window dropped, next frame starts clean.
        send_frame(1'b0, 30, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        w0 = n_win;
        send_frame(1'b0, -1, 1'b0);
        drain();
        chk("after_rst_windows", n_win - w0, 144);

        // Random valid/ready toggling over ten frames.
        rnd_mode = 1'b1;
        w0 = n_win;
        for (int f = 0; f < 10; f++) begin
            send_frame(1'b1, -1, 1'b0);
        end
        drain();
        rnd_mode = 1'b0;
        chk("random_windows", n_win - w0, 1440);

        repeat (3) @(posedge clk);
        #1;
        chk("final_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
